// File: rtl/diff_freq_serial_pkg.sv
// Shared definitions for the dual-rate serial link (transmitter and receiver).
//   - line idle levels, repeat/one-shot mode codes, speed select codes
//   - receiver state enum
//   - default word width and tick counts for a 10 MHz system clock
//   - 2-of-3 majority helper used by the optional mid-bit voting sampler
package diff_freq_serial_pkg;

  localparam logic IDLE_LOW   = 1'b0;
  localparam logic IDLE_HIGH  = 1'b1;
  localparam logic ONE_SHOT   = 1'b0;
  localparam logic REPEAT     = 1'b1;
  localparam logic LOW_SPEED  = 1'b0;
  localparam logic HIGH_SPEED = 1'b1;

  localparam int DEF_DATA_BIT    = 8;
  localparam int DEF_TICK_10K_HZ = 1000;
  localparam int DEF_TICK_20K_HZ = 500;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/diff_freq_serial_in_if.sv
// Control / data bundle of the serial receiver.
//   i_sel_freq  : 0 = low speed, 1 = high speed (latched at word start and each bit end)
//   i_start     : one-cycle pulse, begins a word
//   i_stop      : ends repeat reception after the current word
//   i_mode      : 0 = one-shot, 1 = repeat
//   i_data      : serial line, idle low, LSB first
//   o_bit_tick  : one-cycle pulse at the end of each bit period
//   o_data      : last completed word
//   o_done_tick : one-cycle pulse when o_data updates
//   o_busy      : high while receiving
// Modport slave is the receiver side, master the driving side.
interface diff_freq_serial_in_if
  import diff_freq_serial_pkg::*;
#(
  parameter int DATA_BIT = DEF_DATA_BIT
);
  logic                i_sel_freq;
  logic                i_start;
  logic                i_stop;
  logic                i_mode;
  logic                i_data;
  logic                o_bit_tick;
  logic [DATA_BIT-1:0] o_data;
  logic                o_done_tick;
  logic                o_busy;

  modport master (
    output i_sel_freq, i_start, i_stop, i_mode, i_data,
    input  o_bit_tick, o_data, o_done_tick, o_busy
  );

  modport slave (
    input  i_sel_freq, i_start, i_stop, i_mode, i_data,
    output o_bit_tick, o_data, o_done_tick, o_busy
  );
endinterface

// File: rtl/diff_freq_serial_in_bit_period_timer.sv
// bit_period_timer: per-bit cycle counter shared by the serial transmitter
// and receiver. While i_run is high the counter runs 0..N-1 and wraps, with
// N = TICK_20K_HZ when i_sel_freq is high, else TICK_10K_HZ. While i_run is
// low it holds 0, so the first running cycle is cycle 0 of a bit.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_run           : counter enable
//   i_sel_freq      : latched period select (must only change at a wrap)
//   o_sample_pre    : strobe at count N/2-1 (SAMPLE_MAJORITY_EN only)
//   o_sample_post   : strobe at count N/2+1 (SAMPLE_MAJORITY_EN only)
//   o_sample        : strobe at count N/2
//   o_bit_end       : strobe at count N-1
// Optional feature macro: SAMPLE_MAJORITY_EN adds the two flanking strobes.
module bit_period_timer
  import diff_freq_serial_pkg::*;
#(
  parameter int TICK_10K_HZ = DEF_TICK_10K_HZ,
  parameter int TICK_20K_HZ = DEF_TICK_20K_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_sel_freq,
`ifdef SAMPLE_MAJORITY_EN
  output logic o_sample_pre,
  output logic o_sample_post,
`endif
  output logic o_sample,
  output logic o_bit_end
);
  localparam int CW = $clog2(TICK_10K_HZ);

  localparam logic [CW-1:0] LAST_LO = CW'(TICK_10K_HZ - 1);
  localparam logic [CW-1:0] LAST_HI = CW'(TICK_20K_HZ - 1);
  localparam logic [CW-1:0] MID_LO  = CW'(TICK_10K_HZ / 2);
  localparam logic [CW-1:0] MID_HI  = CW'(TICK_20K_HZ / 2);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] last_cnt, mid_cnt;

  always_comb begin
    last_cnt = i_sel_freq ? LAST_HI : LAST_LO;
    mid_cnt  = i_sel_freq ? MID_HI : MID_LO;
    count_d  = '0;
    if (i_run && (count_q != last_cnt)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_sample  = i_run && (count_q == mid_cnt);
  assign o_bit_end = i_run && (count_q == last_cnt);

`ifdef SAMPLE_MAJORITY_EN
  // N >= 4 keeps both flanking counts inside 0..N-1.
  assign o_sample_pre  = i_run && (count_q == mid_cnt - CW'(1));
  assign o_sample_post = i_run && (count_q == mid_cnt + CW'(1));
`endif

endmodule

// File: rtl/diff_freq_serial_in.sv
// diff_freq_serial_in: deserialises a DATA_BIT word, LSB first, from an
// idle-low serial line running at 10 kHz or 20 kHz (selectable per bit),
// aligned by an i_start pulse shared with the transmitter.
// Ports:
//   clk  : 10 MHz system clock
//   rst  : synchronous active-high reset (aborts any word, clears o_data)
//   bus  : diff_freq_serial_in_if.slave (controls, serial line, outputs)
// Optional feature macro: SAMPLE_MAJORITY_EN -- each bit is the 2-of-3 vote
// of samples at counts N/2-1, N/2, N/2+1 instead of a single sample at N/2.
module diff_freq_serial_in
  import diff_freq_serial_pkg::*;
#(
  parameter int DATA_BIT    = DEF_DATA_BIT,
  parameter int TICK_10K_HZ = DEF_TICK_10K_HZ,
  parameter int TICK_20K_HZ = DEF_TICK_20K_HZ
) (
  input  logic                  clk,
  input  logic                  rst,
  diff_freq_serial_in_if.slave  bus
);
  localparam int IW = $clog2(DATA_BIT) + 1;

  rx_state_e           state_q, state_d;
  logic                mode_q, mode_d;
  logic                speed_q, speed_d;
  logic                stop_seen_q, stop_seen_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                bit_tick_q, bit_tick_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                smp_mid, bit_end;
`ifdef SAMPLE_MAJORITY_EN
  logic                smp_pre, smp_post;
  logic [1:0]          vote_q, vote_d;   // [0] = early sample, [1] = centre sample
`endif

  bit_period_timer #(
    .TICK_10K_HZ (TICK_10K_HZ),
    .TICK_20K_HZ (TICK_20K_HZ)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .i_run         (state_q == RECV),
    .i_sel_freq    (speed_q),
`ifdef SAMPLE_MAJORITY_EN
    .o_sample_pre  (smp_pre),
    .o_sample_post (smp_post),
`endif
    .o_sample      (smp_mid),
    .o_bit_end     (bit_end)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    speed_d     = speed_q;
    stop_seen_d = stop_seen_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    bit_tick_d  = 1'b0;
    done_d      = 1'b0;
`ifdef SAMPLE_MAJORITY_EN
    vote_d      = vote_q;
`endif

    unique case (state_q)
      IDLE: begin
        // i_stop blocks a simultaneous i_start.
        if (bus.i_start && !bus.i_stop) begin
          state_d     = RECV;
          mode_d      = bus.i_mode;
          speed_d     = bus.i_sel_freq;
          idx_d       = '0;
          stop_seen_d = 1'b0;
        end
      end

      RECV: begin
        if (bus.i_stop) begin
          stop_seen_d = 1'b1;
        end

`ifdef SAMPLE_MAJORITY_EN
        if (smp_pre) vote_d[0] = bus.i_data;
        if (smp_mid) vote_d[1] = bus.i_data;
        if (smp_post) begin
          shift_d = {majority3(vote_q[0], vote_q[1], bus.i_data), shift_q[DATA_BIT-1:1]};
        end
`else
        if (smp_mid) begin
          shift_d = {bus.i_data, shift_q[DATA_BIT-1:1]};
        end
`endif

        if (bit_end) begin
          bit_tick_d = 1'b1;
          speed_d    = bus.i_sel_freq;
          if (idx_q == IW'(DATA_BIT - 1)) begin
            // shift_d rather than shift_q: with N == 4 the voted commit
            // lands on the same edge as the word end.
            data_d      = shift_d;
            done_d      = 1'b1;
            idx_d       = '0;
            stop_seen_d = 1'b0;
            if ((mode_q == ONE_SHOT) || stop_seen_q || bus.i_stop) begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      speed_q     <= 1'b0;
      stop_seen_q <= 1'b0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      bit_tick_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SAMPLE_MAJORITY_EN
      vote_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      speed_q     <= speed_d;
      stop_seen_q <= stop_seen_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      bit_tick_q  <= bit_tick_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
`ifdef SAMPLE_MAJORITY_EN
      vote_q      <= vote_d;
`endif
    end
  end

  assign bus.o_bit_tick  = bit_tick_q;
  assign bus.o_data      = data_q;
  assign bus.o_done_tick = done_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_diff_freq_serial_in.sv
`timescale 1ns/1ps
module tb_diff_freq_serial_in;
  localparam int T10 = 1000;
  localparam int T20 = 500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  diff_freq_serial_in_if #(.DATA_BIT(8)) bus ();

  diff_freq_serial_in #(
    .DATA_BIT    (8),
    .TICK_10K_HZ (T10),
    .TICK_20K_HZ (T20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #50 clk = ~clk;                 // 10 MHz
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Scoreboard: driver pushes, monitor pops.
  typedef struct {
    logic [7:0] data;
    int         at;
    bit         last;
  } done_t;
  done_t done_q[$];
  int    tick_q[$];

  // Word schedule used by the driver and the reference model.
  logic [7:0] w_data   [4];
  bit         w_spd    [4][8];
  logic [7:0] w_glitch [4];
  int         start_cyc;

  function automatic int per(input bit s);
    return s ? T20 : T10;
  endfunction

  // A glitch inverts the line only during the centre cycle of a bit: a single
  // centre sample sees it, a 2-of-3 vote around the centre outvotes it.
  function automatic logic [7:0] expect_word(input int w);
    logic [7:0] r;
    r = w_data[w];
`ifndef SAMPLE_MAJORITY_EN
    r = r ^ w_glitch[w];
`endif
    return r;
  endfunction

  task automatic set_word(input int w, input logic [7:0] d, input int spd_mode);
    // spd_mode: 0 low, 1 high, 2 alternate starting high, 3 random
    w_data[w]   = d;
    w_glitch[w] = 8'h00;
    for (int b = 0; b < 8; b++) begin
      case (spd_mode)
        0:       w_spd[w][b] = 1'b0;
        1:       w_spd[w][b] = 1'b1;
        2:       w_spd[w][b] = ((b % 2) == 0);
        default: w_spd[w][b] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Drives nw back-to-back words like the transmitter would. stop_last pulses
  // i_stop during the last word; abort_bit >= 0 resets mid-way through that
  // bit of word 0 instead of finishing.
  task automatic run(input int nw, input bit mode, input bit stop_last, input int abort_bit);
    int t;
    int n;
    bit nxt;
    t = 0;
    bus.i_start    = 1'b1;
    bus.i_mode     = mode;
    bus.i_sel_freq = w_spd[0][0];
    start_cyc      = cyc + 1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 8; b++) begin
        n = per(w_spd[w][b]);
        if (b < 7)           nxt = w_spd[w][b+1];
        else if (w + 1 < nw) nxt = w_spd[w+1][0];
        else                 nxt = 1'($urandom_range(0, 1));
        bus.i_sel_freq = nxt;
        if (w == 0 && b == abort_bit) begin
          repeat (n / 2) begin
            bus.i_data = w_data[w][b];
            @(negedge clk);
          end
          rst = 1'b1;
          @(negedge clk);
          chk("abort_bit_tick", bus.o_bit_tick, 0);
          chk("abort_done_tick", bus.o_done_tick, 0);
          chk("abort_busy", bus.o_busy, 0);
          chk("abort_data", bus.o_data, 0);
          rst = 1'b0;
          bus.i_data = 1'b0;
          repeat (20) @(negedge clk);
          return;
        end
        t += n;
        tick_q.push_back(start_cyc + t);
        if (b == 7) done_q.push_back('{expect_word(w), start_cyc + t, (w == nw - 1)});
        for (int c = 0; c < n; c++) begin
          bus.i_data  = w_data[w][b] ^ (w_glitch[w][b] && (c == n / 2));
          bus.i_start = (w == 0 && b == 2 && c == 5);   // ignored while receiving
          bus.i_stop  = stop_last && (w == nw - 1) && (b == 3) && (c == 10);
          @(negedge clk);
        end
      end
    end
    bus.i_data  = 1'b0;
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy_after_run", bus.o_busy, 0);
  endtask

  // Monitor
  done_t exp_done;
  int    exp_tick;
  always @(negedge clk) begin
    if (bus.o_bit_tick) begin
      if (tick_q.size() == 0) begin
        chk("bit_tick_unexpected", cyc, -1);
      end else begin
        exp_tick = tick_q.pop_front();
        chk("bit_tick_cycle", cyc, exp_tick);
      end
    end
    if (bus.o_done_tick) begin
      $display("done: data=0x%02h at cycle %0d busy=%0d", bus.o_data, cyc, bus.o_busy);
      if (done_q.size() == 0) begin
        chk("done_tick_unexpected", cyc, -1);
      end else begin
        exp_done = done_q.pop_front();
        chk("done_data", bus.o_data, exp_done.data);
        chk("done_cycle", cyc, exp_done.at);
        chk("done_busy", bus.o_busy, !exp_done.last);
      end
    end
  end

  initial begin
    bus.i_sel_freq = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_stop     = 1'b0;
    bus.i_mode     = 1'b0;
    bus.i_data     = 1'b0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_bit_tick", bus.o_bit_tick, 0);
    chk("reset_done_tick", bus.o_done_tick, 0);
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_data", bus.o_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // High speed one-shot 0x55 (4000 clocks)
    set_word(0, 8'h55, 1);
    run(1, 1'b0, 1'b0, -1);

    // Low speed one-shot 0xAA, i_stop pulsed mid-word has no effect
    set_word(0, 8'hAA, 0);
    run(1, 1'b0, 1'b1, -1);

    // Per-bit speed alternation 500/1000 (6000 clocks)
    set_word(0, 8'h55, 2);
    run(1, 1'b0, 1'b0, -1);

    // Repeat mode, three words back-to-back, stop during the third
    set_word(0, 8'h3C, 1);
    set_word(1, 8'hC3, 1);
    set_word(2, 8'h0F, 1);
    run(3, 1'b1, 1'b1, -1);

    // Simultaneous start and stop in IDLE: stays idle
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_stop_idle_busy", bus.o_busy, 0);

    // Reset during bit 4, then a clean 0xA5
    set_word(0, 8'(($urandom_range(0, 255))), 1);
    run(1, 1'b0, 1'b0, 4);
    set_word(0, 8'hA5, 1);
    run(1, 1'b0, 1'b0, -1);

    // Single-cycle centre glitch on bit 0 (a 1)
    set_word(0, 8'h5D, 1);
    w_glitch[0] = 8'h01;
    run(1, 1'b0, 1'b0, -1);

    // Randomised one-shot words and a randomised repeat burst
    for (int k = 0; k < 2; k++) begin
      set_word(0, 8'($urandom_range(0, 255)), 3);
      run(1, 1'b0, 1'b0, -1);
    end
    set_word(0, 8'($urandom_range(0, 255)), 3);
    set_word(1, 8'($urandom_range(0, 255)), 3);
    run(2, 1'b1, 1'b1, -1);

    repeat (10) @(negedge clk);
    chk("tick_queue_drained", tick_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    chk("final_busy", bus.o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/diff_freq_serial_in.md
Name: diff_freq_serial_in

Overview:
Receive-side counterpart of diff_freq_serial_out. It deserialises a DATA_BIT-wide word from a single idle-low serial line whose bit rate is 10 kHz or 20 kHz and may change per bit. Bit timing comes from the 10 MHz system clock. Word alignment comes from an i_start pulse shared with, or mirrored from, the transmitter. It sits beside the serial transmitter in loopback/self-test paths and feeds parallel words to downstream logic.

Parameters:
DATA_BIT, 8, bits per word; LSB received first.
TICK_10K_HZ, 1000, system clocks per low-speed bit; must be >= TICK_20K_HZ.
TICK_20K_HZ, 500, system clocks per high-speed bit; must be >= 4.

Ports:
clk  input  1  system clock, 10 MHz.
rst  input  1  synchronous, active-high reset.
i_sel_freq  input  1  0 = low speed (TICK_10K_HZ), 1 = high speed (TICK_20K_HZ).
i_start  input  1  one-cycle pulse; begins a word.
i_stop  input  1  ends repeat reception after the current word.
i_mode  input  1  0 = one-shot, 1 = repeat.
i_data  input  1  serial line, idle low.
o_bit_tick  output  1  one-cycle pulse at the end of each bit period.
o_data  output  DATA_BIT  last completed word.
o_done_tick  output  1  one-cycle pulse when o_data updates.
o_busy  output  1  high while not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst is high, every output is 0, the state is IDLE, and all counters and the shift register are 0. Asserting rst mid-word aborts the word: no done tick, o_data cleared.
- Outputs: all registered.
- States:
  - IDLE: waits for i_start.
  - RECV: shifting bits.
  - Simultaneous i_start and i_stop in IDLE: i_stop wins and the block stays IDLE.
- Start: when i_start=1 in IDLE, on that edge latch i_mode and i_sel_freq, clear the bit counter and bit index, and go to RECV. The next cycle is cycle 0 of bit 0. i_start while RECV is ignored.
- Per-bit timing:
  - N is TICK_20K_HZ or TICK_10K_HZ, chosen by the latched speed.
  - The counter runs 0..N-1.
  - Sample i_data when count == N/2 (integer divide).
  - When count == N-1: o_bit_tick=1 on the next cycle, count wraps to 0, and i_sel_freq is re-latched for the next bit.
  - A mid-bit change of i_sel_freq has no effect on the current bit.
- Shift register: the sampled bit is shifted in from the MSB side, so after DATA_BIT samples bit 0 sits at the LSB.
- Word end: at the last bit's count == N-1 edge, o_data takes the shift value and o_done_tick=1 for one cycle. This coincides with that bit's o_bit_tick.
  - One-shot: go to IDLE.
  - Repeat: if i_stop was seen at any time during the word (sticky flag, cleared at word end), go to IDLE. Otherwise continue immediately with bit 0 of the next word with no gap, and re-latch speed.
- i_stop in one-shot: no effect; the word always completes.
- Latency: with constant speed, o_done_tick is high in the cycle that begins DATA_BIT*N edges after the i_start edge. Default high speed: 4000 clocks; low speed: 8000 clocks.
- Width rules: counter is $clog2(TICK_10K_HZ) bits; bit index is $clog2(DATA_BIT)+1 bits; no overflow is possible.

Optional Feature:
SAMPLE_MAJORITY_EN
- Defined: i_data is sampled at count N/2-1, N/2 and N/2+1. The shifted bit is the 2-of-3 majority, committed at N/2+1.
- Undefined: a single sample at N/2.
- Timing of o_bit_tick and o_done_tick is identical either way.

Decomposition:
- Shared package diff_freq_serial_pkg holds:
  - constants IDLE_LOW, IDLE_HIGH, ONE_SHOT, REPEAT, LOW_SPEED, HIGH_SPEED;
  - the receiver state enum (IDLE, RECV);
  - default tick counts.
- Sub-module bit_period_timer: takes the latched period select, TICK_10K_HZ and TICK_20K_HZ. It produces the mid-bit sample strobe (or three strobes under SAMPLE_MAJORITY_EN) and the end-of-bit strobe. The transmitter can reuse it.

Test Plan:
1. High speed, one-shot: drive 0x55 LSB-first, 500 clocks per bit, pulse i_start -> o_done_tick 4000 clocks after the start edge, o_data=0x55, 8 o_bit_ticks, o_busy then low.
2. Low speed, one-shot: drive 0xAA at 1000 clocks per bit -> done after 8000 clocks, o_data=0xAA.
3. Per-bit speed change: start at high speed with 0x55 and toggle i_sel_freq after each o_bit_tick (mirroring the transmitter) -> bit periods alternate 500/1000, o_data=0x55, done at 4*500+4*1000=6000 clocks.
4. Repeat mode: send 0x3C, 0xC3, 0x0F back-to-back and assert i_stop during the third word -> three done ticks 4000 apart with matching o_data, then IDLE.
5. Reset mid-word: assert rst for one cycle during bit 4 -> all outputs 0, no done tick; a following i_start receives 0xA5 correctly.
6. Glitch at mid-bit, SAMPLE_MAJORITY_EN defined: in a 1 bit, i_data is 0 for only the cycle at count 250 -> bit read as 1; without the macro the bit reads as 0.
